// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared constants, FSM states and window packing for the edge-detect feeder
package edge_detect_pkg;

  localparam int PIX_W    = 8;
  localparam int WORD_PIX = 4;
  localparam int WIN_W    = 72;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, DRAIN} state_t;

  // Each row argument is three pixels with [7:0] = leftmost; top row lands in [23:0].
  function automatic logic [WIN_W-1:0] pack_window(input logic [3*PIX_W-1:0] top,
                                                   input logic [3*PIX_W-1:0] mid,
                                                   input logic [3*PIX_W-1:0] bot);
    return {bot, mid, top};
  endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// rtl/edge_line_buffer.sv - two image-row line buffers, read-before-write at one column index
module edge_line_buffer
  import edge_detect_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk_50M,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] lb1_q,
  output logic [PIX_W-1:0] lb2_q
);

  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];

  assign lb1_q = lb1[idx];
  assign lb2_q = lb2[idx];

  // lb1 holds the previous row, lb2 the row before it; contents need no reset.
  always_ff @(posedge clk_50M) begin
    if (we) begin
      lb2[idx] <= lb1[idx];
      lb1[idx] <= pix;
    end
  end

endmodule

// File: rtl/edge_window_fetch.sv
// rtl/edge_window_fetch.sv - raster image fetch emitting interior 3x3 windows; WIN_COORD_EN adds win_x/win_y
module edge_window_fetch
  import edge_detect_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] address_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [31:0]       ram_q,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [WIN_W-1:0]  win_data,
  output logic              win_last
`ifdef WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int WORDS  = IMG_W * IMG_H / WORD_PIX;
  localparam int WIDX_W = $clog2(WORDS);

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [WIDX_W-1:0]   word_idx;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [1:0]          sub;
  logic [31:0]         word_reg;
  logic [3*PIX_W-1:0]  top_t, mid_t, bot_t;
  logic [PIX_W-1:0]    pix, lb1_q, lb2_q;
  logic [3*PIX_W-1:0]  top_n, mid_n, bot_n;
  logic                emit, step, col_last, row_last, word_last;

  assign pix       = word_reg[{sub, 3'b000} +: PIX_W];
  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign row_last  = (row == ROW_W'(IMG_H - 1));
  assign word_last = (word_idx == WIDX_W'(WORDS - 1));
  assign emit      = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  // A step that would emit into a full, unaccepted register must freeze everything.
  assign step      = (state == SHIFT) && (!emit || !win_valid || win_ready);

  assign top_n = {lb2_q, top_t[3*PIX_W-1:PIX_W]};
  assign mid_n = {lb1_q, mid_t[3*PIX_W-1:PIX_W]};
  assign bot_n = {pix,   bot_t[3*PIX_W-1:PIX_W]};

  edge_line_buffer #(
    .IMG_W(IMG_W),
    .IDX_W(COL_W)
  ) u_line_buffer (
    .clk_50M(clk_50M),
    .we     (step),
    .idx    (col),
    .pix    (pix),
    .lb1_q  (lb1_q),
    .lb2_q  (lb2_q)
  );

  always_ff @(posedge clk_50M) begin
    if (step) begin
      top_t <= top_n;
      mid_t <= mid_n;
      bot_t <= bot_n;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      win_valid     <= 1'b0;
      win_last      <= 1'b0;
      win_data      <= '0;
      ram_rdaddress <= '0;
      base          <= '0;
      word_idx      <= '0;
      col           <= '0;
      row           <= '0;
      sub           <= '0;
      word_reg      <= '0;
`ifdef WIN_COORD_EN
      win_x         <= '0;
      win_y         <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
      if (step && emit) begin
        win_valid <= 1'b1;
        win_data  <= pack_window(top_n, mid_n, bot_n);
        win_last  <= col_last && row_last;
`ifdef WIN_COORD_EN
        win_x     <= col - 1'b1;
        win_y     <= row - 1'b1;
`endif
      end
      case (state)
        IDLE: begin
          if (start && !done) begin
            base     <= address_base;
            word_idx <= '0;
            col      <= '0;
            row      <= '0;
            sub      <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          ram_rdaddress <= base + ADDR_W'(word_idx);
          state         <= CAPTURE;
        end
        CAPTURE: begin
          word_reg <= ram_q;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (step) begin
            sub <= sub + 1'b1;
            if (col_last) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (sub == 2'(WORD_PIX - 1)) begin
              word_idx <= word_idx + 1'b1;
              state    <= word_last ? DRAIN : FETCH;
            end
          end
        end
        DRAIN: begin
          if (!win_valid) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_window_fetch.sv
// tb/tb_edge_window_fetch.sv - directed self-checking bench for edge_window_fetch (64x64 and 8x3 builds)
module tb_edge_window_fetch;

  localparam int W = 64, H = 64, NWIN = (W - 2) * (H - 2);

  logic        clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  logic        reset, start, busy, done, win_valid, win_ready, win_last;
  logic [11:0] address_base, ram_rdaddress;
  logic [31:0] ram_q;
  logic [71:0] win_data;
  logic        s_reset, s_start, s_busy, s_done, s_win_valid, s_win_ready, s_win_last;
  logic [11:0] s_address_base, s_ram_rdaddress;
  logic [31:0] s_ram_q;
  logic [71:0] s_win_data;
`ifdef WIN_COORD_EN
  logic [5:0]  win_x, win_y;
  logic [2:0]  s_win_x;
  logic [1:0]  s_win_y;
`endif

  logic [31:0] mem  [4096];
  logic [31:0] smem [4096];
  bit          seen [4096];
  assign ram_q   = mem[ram_rdaddress];
  assign s_ram_q = smem[s_ram_rdaddress];

  edge_window_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(12)) dut (
    .clk_50M(clk_50M), .reset(reset), .start(start), .address_base(address_base),
    .busy(busy), .done(done), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_last(win_last)
`ifdef WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  edge_window_fetch #(.IMG_W(8), .IMG_H(3), .ADDR_W(12)) dut_small (
    .clk_50M(clk_50M), .reset(s_reset), .start(s_start), .address_base(s_address_base),
    .busy(s_busy), .done(s_done), .ram_rdaddress(s_ram_rdaddress), .ram_q(s_ram_q),
    .win_valid(s_win_valid), .win_ready(s_win_ready), .win_data(s_win_data), .win_last(s_win_last)
`ifdef WIN_COORD_EN
    , .win_x(s_win_x), .win_y(s_win_y)
`endif
  );

  int checks = 0, errors = 0;
  int r_win, r_bad, r_bad_last, r_done, r_unstable, r_stall, r_addr, r_oor;
  logic r_busy_at_done, r_timeout;
  logic [71:0] r_first;

  function automatic logic [7:0] pixv(input int x, input int y);
    logic [31:0] s;
    s = x + y;
    return s[7:0];
  endfunction

  function automatic logic [71:0] exp_win(input int cx, input int cy);
    logic [71:0] w;
    w = '0;
    for (int r = 2; r >= 0; r--)
      for (int c = 2; c >= 0; c--)
        w = {w[63:0], pixv(cx - 1 + c, cy - 1 + r)};
    return w;
  endfunction

  task automatic fill_big(input logic [11:0] b);
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_A5A5;
    for (int y = 0; y < H; y++)
      for (int xw = 0; xw < W / 4; xw++) begin
        a = b + 12'(y * (W / 4) + xw);
        mem[a] = {pixv(4*xw+3, y), pixv(4*xw+2, y), pixv(4*xw+1, y), pixv(4*xw, y)};
      end
  endtask

  // Runs one 64x64 image and records what was observed; the calling test does the checks.
  task automatic run_big(input logic [11:0] b, input bit rnd, input int abort_after);
    logic prev_stall, held_l;
    logic [71:0] held_d;
    logic [11:0] off;
    r_win = 0; r_bad = 0; r_bad_last = 0; r_done = 0; r_unstable = 0; r_stall = 0;
    r_addr = 0; r_oor = 0; r_busy_at_done = 1'b1; r_timeout = 1'b1; r_first = '0;
    foreach (seen[i]) seen[i] = 1'b0;
    fill_big(b);
    address_base = b;
    win_ready = 1'b1;
    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    prev_stall = 1'b0; held_d = '0; held_l = 1'b0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (cyc > 0) @(negedge clk_50M);
      if (busy && cyc > 0 && !seen[ram_rdaddress]) begin
        seen[ram_rdaddress] = 1'b1;
        r_addr++;
        off = ram_rdaddress - b;
        if (off >= 12'd1024) r_oor++;
      end
      if (prev_stall && (win_valid !== 1'b1 || win_data !== held_d || win_last !== held_l))
        r_unstable++;
      if (done) begin
        r_done++;
        r_busy_at_done = busy;
        r_timeout = 1'b0;
        break;
      end
      if (rnd) win_ready = (cyc >= 500 && cyc < 520) ? 1'b0 : 1'($urandom_range(0, 1));
      else     win_ready = 1'b1;
      if (win_valid && win_ready) begin
        if (r_win == 0) r_first = win_data;
        if (win_data !== exp_win(1 + r_win % (W - 2), 1 + r_win / (W - 2))) r_bad++;
        if (win_last !== (r_win == NWIN - 1)) r_bad_last++;
        r_win++;
        if (r_win == abort_after) begin
          r_timeout = 1'b0;
          break;
        end
      end
      prev_stall = win_valid && !win_ready;
      if (prev_stall) r_stall++;
      held_d = win_data;
      held_l = win_last;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk_50M);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", win_valid); end
    checks++; if (win_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", win_last); end
    checks++; if (ram_rdaddress !== 12'h000) begin errors++; $display("FAIL reset_addr got=%h exp=000", ram_rdaddress); end
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk_50M);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_ramp;
    run_big(12'h000, 1'b0, 0);
    checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL ramp_timeout got=%b exp=0", r_timeout); end
    checks++; if (r_win != NWIN) begin errors++; $display("FAIL ramp_count got=%0d exp=%0d", r_win, NWIN); end
    checks++; if (r_bad != 0) begin errors++; $display("FAIL ramp_data bad=%0d exp=0", r_bad); end
    checks++; if (r_bad_last != 0) begin errors++; $display("FAIL ramp_last bad=%0d exp=0", r_bad_last); end
    checks++; if (r_first !== {8'd4, 8'd3, 8'd2, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd0})
      begin errors++; $display("FAIL ramp_first got=%h exp=040302030201020100", r_first); end
    checks++; if (r_done != 1) begin errors++; $display("FAIL ramp_done got=%0d exp=1", r_done); end
    checks++; if (r_busy_at_done !== 1'b0) begin errors++; $display("FAIL ramp_busy_at_done got=%b exp=0", r_busy_at_done); end
    checks++; if (r_addr != 1024) begin errors++; $display("FAIL ramp_addrs got=%0d exp=1024", r_addr); end
    checks++; if (r_oor != 0) begin errors++; $display("FAIL ramp_addr_range got=%0d exp=0", r_oor); end
  endtask

  task automatic test_base_wrap;
    run_big(12'hE00, 1'b0, 0);
    checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL wrap_timeout got=%b exp=0", r_timeout); end
    checks++; if (r_win != NWIN) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", r_win, NWIN); end
    checks++; if (r_bad != 0) begin errors++; $display("FAIL wrap_data bad=%0d exp=0", r_bad); end
    checks++; if (r_bad_last != 0) begin errors++; $display("FAIL wrap_last bad=%0d exp=0", r_bad_last); end
    checks++; if (r_addr != 1024) begin errors++; $display("FAIL wrap_addrs got=%0d exp=1024", r_addr); end
    checks++; if (r_oor != 0) begin errors++; $display("FAIL wrap_addr_range got=%0d exp=0", r_oor); end
  endtask

  task automatic test_backpressure;
    run_big(12'h000, 1'b1, 0);
    checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got=%b exp=0", r_timeout); end
    checks++; if (r_win != NWIN) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", r_win, NWIN); end
    checks++; if (r_bad != 0) begin errors++; $display("FAIL bp_data bad=%0d exp=0", r_bad); end
    checks++; if (r_bad_last != 0) begin errors++; $display("FAIL bp_last bad=%0d exp=0", r_bad_last); end
    checks++; if (r_unstable != 0) begin errors++; $display("FAIL bp_stable bad=%0d exp=0", r_unstable); end
    checks++; if (r_stall < 20) begin errors++; $display("FAIL bp_stalls got=%0d exp>=20", r_stall); end
    checks++; if (r_done != 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", r_done); end
  endtask

  task automatic test_mid_reset;
    int nd;
    run_big(12'h000, 1'b0, 100);
    checks++; if (r_win != 100) begin errors++; $display("FAIL abort_count got=%0d exp=100", r_win); end
    reset = 1'b1;
    @(negedge clk_50M);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", win_valid); end
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50M);
      if (done || busy) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
    run_big(12'h000, 1'b0, 0);
    checks++; if (r_win != NWIN) begin errors++; $display("FAIL rerun_count got=%0d exp=%0d", r_win, NWIN); end
    checks++; if (r_bad != 0 || r_bad_last != 0) begin errors++; $display("FAIL rerun_data bad=%0d last=%0d exp=0", r_bad, r_bad_last); end
    checks++; if (r_done != 1) begin errors++; $display("FAIL rerun_done got=%0d exp=1", r_done); end
  endtask

  task automatic test_small;
    int n, bad, bad_last, nd, busy_after, coord_bad;
    bit saw_done;
    for (int i = 0; i < 4096; i++) smem[i] = 32'h5A5A_5A5A;
    for (int y = 0; y < 3; y++)
      for (int xw = 0; xw < 2; xw++)
        smem[12'(y * 2 + xw)] = {pixv(4*xw+3, y), pixv(4*xw+2, y), pixv(4*xw+1, y), pixv(4*xw, y)};
    s_reset = 1'b1; s_start = 1'b0; s_win_ready = 1'b1; s_address_base = 12'h000;
    repeat (2) @(negedge clk_50M);
    s_reset = 1'b0;
    @(negedge clk_50M); s_start = 1'b1;
    @(negedge clk_50M); s_start = 1'b0;
    n = 0; bad = 0; bad_last = 0; nd = 0; busy_after = 0; coord_bad = 0; saw_done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk_50M);
      if (saw_done && s_busy) busy_after++;
      if (s_done) begin nd++; saw_done = 1'b1; end
      if (s_win_valid && s_win_ready) begin
        if (s_win_data !== exp_win(1 + n, 1)) bad++;
        if (s_win_last !== (n == 5)) bad_last++;
`ifdef WIN_COORD_EN
        if (s_win_x !== 3'(1 + n) || s_win_y !== 2'd1) coord_bad++;
`endif
        n++;
      end
      s_start = (cyc == 3 || cyc == 12 || s_done);
    end
    s_start = 1'b0;
    checks++; if (n != 6) begin errors++; $display("FAIL small_count got=%0d exp=6", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL small_data bad=%0d exp=0", bad); end
    checks++; if (bad_last != 0) begin errors++; $display("FAIL small_last bad=%0d exp=0", bad_last); end
    checks++; if (nd != 1) begin errors++; $display("FAIL small_done got=%0d exp=1", nd); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL small_restart got=%0d exp=0", busy_after); end
    checks++; if (coord_bad != 0) begin errors++; $display("FAIL small_coord bad=%0d exp=0", coord_bad); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; win_ready = 1'b0; address_base = 12'h000;
    s_reset = 1'b1; s_start = 1'b0; s_win_ready = 1'b0; s_address_base = 12'h000;
    test_reset();
    test_ramp();
    test_base_wrap();
    test_backpressure();
    test_mid_reset();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
